// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: FSM encoding, counter width, bit-period helper
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RECV  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int COUNT_REG_LEN = 16;

    function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchroniser with configurable reset value
module uart_sync2 #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: deserialises 8N1-style frames, flags framing errors and breaks
module uart_rx
    import uart_pkg::*;
#(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 50000000,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_break,
    output logic                    uart_rx_frame_err,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data
);

    localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int HALF_BIT       = CYCLES_PER_BIT / 2;

    localparam logic [COUNT_REG_LEN-1:0] BIT_LAST  = COUNT_REG_LEN'(CYCLES_PER_BIT - 1);
    localparam logic [COUNT_REG_LEN-1:0] HALF_LAST = COUNT_REG_LEN'(HALF_BIT - 1);
    localparam logic [3:0]               DATA_LAST = 4'(PAYLOAD_BITS - 1);
    localparam logic [3:0]               STOP_LAST = 4'(STOP_BITS - 1);

    uart_state_t               state, next_state;
    logic [COUNT_REG_LEN-1:0]  cycle_cnt;
    logic [3:0]                bit_cnt;
    logic [PAYLOAD_BITS-1:0]   shift_reg;
    logic [PAYLOAD_BITS:0]     shift_ext;
    logic                      err;
    logic                      break_hold;
    logic                      frame_done;
    logic                      frame_bad;
    logic                      rxd_s;
    logic                      bit_tick;
    logic                      start_tick;
    logic                      stop_done;
    logic                      bad_now;

    uart_sync2 #(.RESET_VALUE(1'b1)) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (uart_rxd),
        .q      (rxd_s)
    );

    assign bit_tick   = (cycle_cnt == BIT_LAST);
    assign start_tick = (state == START) && (cycle_cnt == HALF_LAST);
    assign stop_done  = (state == STOP) && bit_tick && (bit_cnt == STOP_LAST) && uart_rx_en;
    assign bad_now    = err | ~rxd_s;
    // New bit enters at the MSB; the widened vector keeps this legal for a 1-bit payload.
    assign shift_ext  = {rxd_s, shift_reg};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (uart_rx_en && !rxd_s && !break_hold) next_state = START;
            START: if (cycle_cnt == HALF_LAST) next_state = rxd_s ? IDLE : RECV;
            RECV:  if (bit_tick && bit_cnt == DATA_LAST) next_state = STOP;
            STOP:  if (bit_tick && bit_cnt == STOP_LAST) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (!uart_rx_en) next_state = IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cycle_cnt  <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            err        <= 1'b0;
            break_hold <= 1'b0;
            frame_done <= 1'b0;
            frame_bad  <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (state == IDLE || next_state != state || bit_tick) begin
                cycle_cnt <= '0;
            end else begin
                cycle_cnt <= cycle_cnt + 16'd1;
            end

            if (state == IDLE || start_tick) begin
                bit_cnt <= '0;
                err     <= 1'b0;
            end else if (state == RECV && bit_tick) begin
                shift_reg <= shift_ext[PAYLOAD_BITS:1];
                bit_cnt   <= (bit_cnt == DATA_LAST) ? 4'd0 : bit_cnt + 4'd1;
            end else if (state == STOP && bit_tick) begin
                bit_cnt <= bit_cnt + 4'd1;
                err     <= bad_now;
            end

            if (stop_done) begin
                frame_done <= 1'b1;
                frame_bad  <= bad_now;
            end

            // A break leaves the line low; no new start is accepted until it is seen high.
            if (stop_done && bad_now && shift_reg == '0) begin
                break_hold <= 1'b1;
            end else if (rxd_s) begin
                break_hold <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            uart_rx_valid     <= 1'b0;
            uart_rx_frame_err <= 1'b0;
            uart_rx_break     <= 1'b0;
            uart_rx_data      <= '0;
        end else begin
            uart_rx_valid     <= frame_done && !frame_bad;
            uart_rx_frame_err <= frame_done && frame_bad && (shift_reg != '0);
            uart_rx_break     <= frame_done && frame_bad && (shift_reg == '0);
            if (frame_done && !frame_bad) begin
                uart_rx_data <= shift_reg;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard testbench for uart_rx at 10 clocks per bit
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB = 10;
    localparam int K_VALID = 0;
    localparam int K_FERR  = 1;
    localparam int K_BREAK = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       uart_rx_en = 1'b1;
    logic       uart_rx_break;
    logic       uart_rx_frame_err;
    logic       uart_rx_valid;
    logic [7:0] uart_rx_data;

    exp_t exp_q[$];
    int   valid_times[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    uart_rx #(
        .BIT_RATE     (100000),
        .CLK_HZ       (1000000),
        .PAYLOAD_BITS (8),
        .STOP_BITS    (1)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .uart_rxd          (uart_rxd),
        .uart_rx_en        (uart_rx_en),
        .uart_rx_break     (uart_rx_break),
        .uart_rx_frame_err (uart_rx_frame_err),
        .uart_rx_valid     (uart_rx_valid),
        .uart_rx_data      (uart_rx_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every output pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (resetn) begin
            if (int'(uart_rx_valid) + int'(uart_rx_frame_err) + int'(uart_rx_break) > 1) begin
                vectors++;
                miscompares++;
                $display("FAIL onehot: valid=%0b ferr=%0b brk=%0b, expected at most one",
                         uart_rx_valid, uart_rx_frame_err, uart_rx_break);
            end else if (uart_rx_valid || uart_rx_frame_err || uart_rx_break) begin
                int k;
                k = uart_rx_valid ? K_VALID : (uart_rx_frame_err ? K_FERR : K_BREAK);
                if (k == K_VALID) valid_times.push_back(cyc);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_pulse: kind %0d data 0x%0h, expected none", k, uart_rx_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pulse_kind", k, e.kind);
                    chk("pulse_data", int'(uart_rx_data), int'(e.data));
                end
            end
        end
    end

    task automatic expect_pulse(input int kind, input logic [7:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic drive_bits(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            uart_rxd = bits[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bits({6'h00, stop, d, 1'b0}, 10);
        uart_rxd = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain(input string name, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #1;
        chk("reset_valid", int'(uart_rx_valid), 0);
        chk("reset_ferr", int'(uart_rx_frame_err), 0);
        chk("reset_break", int'(uart_rx_break), 0);
        chk("reset_data", int'(uart_rx_data), 0);
        idle(5);
        resetn = 1'b1;

        idle(200);
        chk("idle_data", int'(uart_rx_data), 8'h00);

        expect_pulse(K_VALID, 8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_drain("drain_a5", 40);
        chk("data_a5", int'(uart_rx_data), 8'hA5);

        valid_times.delete();
        expect_pulse(K_VALID, 8'h3C);
        expect_pulse(K_VALID, 8'hFF);
        send_frame(8'h3C, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_drain("drain_b2b", 40);
        chk("b2b_count", valid_times.size(), 2);
        if (valid_times.size() == 2) begin
            chk("b2b_gap", valid_times[1] - valid_times[0], 100);
        end

        expect_pulse(K_FERR, 8'hFF);
        send_frame(8'h55, 1'b0);
        idle(CPB);
        wait_drain("drain_ferr", 40);
        chk("ferr_data_kept", int'(uart_rx_data), 8'hFF);

        expect_pulse(K_BREAK, 8'hFF);
        uart_rxd = 1'b0;
        idle(15 * CPB);
        uart_rxd = 1'b1;
        wait_drain("drain_break", 10);
        idle(2 * CPB);
        expect_pulse(K_VALID, 8'h12);
        send_frame(8'h12, 1'b1);
        wait_drain("drain_12", 40);

        uart_rxd = 1'b0;
        idle(3);
        uart_rxd = 1'b1;
        idle(50);
        chk("glitch_data", int'(uart_rx_data), 8'h12);

        drive_bits({11'h000, 4'h6, 1'b0}, 5);
        uart_rx_en = 1'b0;
        drive_bits({11'h7FF, 4'h3}, 5);
        uart_rxd = 1'b1;
        idle(50);
        uart_rx_en = 1'b1;
        idle(20);
        chk("en_abort_data", int'(uart_rx_data), 8'h12);
        expect_pulse(K_VALID, 8'h81);
        send_frame(8'h81, 1'b1);
        wait_drain("drain_81", 40);

        drive_bits({11'h000, 4'h7, 1'b0}, 5);
        resetn = 1'b0;
        #1;
        chk("rst_mid_data", int'(uart_rx_data), 0);
        chk("rst_mid_valid", int'(uart_rx_valid), 0);
        chk("rst_mid_state", int'(dut.state), 0);
        uart_rxd = 1'b1;
        idle(3);
        resetn = 1'b1;
        idle(150);
        chk("post_rst_data", int'(uart_rx_data), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, expected $finish");
        $fatal(1);
    end

endmodule
